// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, WIDTH-bit operands, signed/unsigned per operation, valid/ready handshakes.
// Optional accumulate mode (product = running sum of results) enabled by defining SEQ_MULT_ACC_EN.
module seq_mult #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
`ifdef SEQ_MULT_ACC_EN
  input  logic               in_acc,
`endif
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               X,
  output logic [WIDTH-1:0]   Aval,
  output logic [WIDTH-1:0]   Bval
);

  // DONE_ACC is only reachable when the accumulator is built in.
  typedef enum logic [1:0] {IDLE, CALC, DONE_ACC, DONE} state_t;

  state_t             state_r, state_n;
  logic               x_r, mode_r;
  logic [WIDTH-1:0]   a_r, b_r, s_r;
  logic [CNT_W-1:0]   count_r;
  logic               accept_s, last_s;
  logic [WIDTH:0]     ext_a_s, ext_s_s, sum_s;

  assign accept_s  = in_valid && (state_r == IDLE);
  assign last_s    = (count_r == CNT_W'(WIDTH - 1));
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign X         = x_r;
  assign Aval      = a_r;
  assign Bval      = b_r;

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_r <= IDLE;
    else          state_r <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_n = CALC;
        else          state_n = IDLE;
      end
      CALC: begin
        if (last_s) begin
`ifdef SEQ_MULT_ACC_EN
          state_n = DONE_ACC;
`else
          state_n = DONE;
`endif
        end else begin
          state_n = CALC;
        end
      end
      DONE_ACC: state_n = DONE;
      DONE: begin
        if (out_ready) state_n = IDLE;
        else           state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // One add/subtract step; the final multiplier bit carries negative weight in signed mode.
  always_comb begin
    ext_a_s = mode_r ? {a_r[WIDTH-1], a_r} : {1'b0, a_r};
    ext_s_s = mode_r ? {s_r[WIDTH-1], s_r} : {1'b0, s_r};
    if (!b_r[0])               sum_s = {x_r, a_r};
    else if (mode_r && last_s) sum_s = ext_a_s - ext_s_s;
    else                       sum_s = ext_a_s + ext_s_s;
  end

  // Working registers: load on accept, shift {sum,B} right once per CALC cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_r     <= 1'b0;
      mode_r  <= 1'b0;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      s_r     <= {WIDTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      x_r     <= 1'b0;
      mode_r  <= in_signed;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= in_b;
      s_r     <= in_a;
      count_r <= {CNT_W{1'b0}};
    end else if (state_r == CALC) begin
      x_r     <= mode_r ? sum_s[WIDTH] : 1'b0;
      a_r     <= sum_s[WIDTH:1];
      b_r     <= {sum_s[0], b_r[WIDTH-1:1]};
      count_r <= count_r + CNT_W'(1);
    end
  end

`ifdef SEQ_MULT_ACC_EN
  logic [2*WIDTH-1:0] acc_r;
  logic               acc_mode_r;

  // Accumulator updates once, on the way from DONE_ACC into DONE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_r      <= {(2*WIDTH){1'b0}};
      acc_mode_r <= 1'b0;
    end else if (accept_s) begin
      acc_mode_r <= in_acc;
    end else if (state_r == DONE_ACC) begin
      acc_r <= acc_mode_r ? (acc_r + {a_r, b_r}) : {a_r, b_r};
    end
  end

  assign product = acc_r;
`else
  assign product = {a_r, b_r};
`endif

endmodule
